// File: rtl/traffic_cmd_player_if.sv
// Command bus between traffic_cmd_player and the traffic-light controller.
// The player drives the bus (master); the controller consumes it (slave).
interface traffic_cmd_player_if;
  logic [2:0]  cmd_type_o;
  logic        cmd_valid_o;
  logic [15:0] cmd_data_o;

  modport master (
    output cmd_type_o,
    output cmd_valid_o,
    output cmd_data_o
  );

  modport slave (
    input cmd_type_o,
    input cmd_valid_o,
    input cmd_data_o
  );
endinterface

// File: rtl/traffic_cmd_player.sv
// traffic_cmd_player: replays a small programmed script of controller
// commands, each followed by a per-entry delay in milliseconds, once or
// looped. The command strobe/type/data leave through traffic_cmd_player_if.
// Optional build macro TRAFFIC_CMD_PLAYER_TYPE_CHECK_EN: entries with
// command type 6 or 7 are not issued and raise the sticky err_o flag.
module traffic_cmd_player #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned CLKS_PER_MS = 2,
  parameter int unsigned DELAY_W     = 16
) (
  input  logic                       clk_i,
  input  logic                       arstn_i,
  input  logic                       wr_en_i,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr_i,
  input  logic [2:0]                 wr_type_i,
  input  logic [15:0]                wr_data_i,
  input  logic [DELAY_W-1:0]         wr_delay_i,
  input  logic [$clog2(DEPTH+1)-1:0] prog_len_i,
  input  logic                       loop_i,
  input  logic                       start_i,
  input  logic                       stop_i,
  traffic_cmd_player_if.master       cmd_if,
  output logic                       busy_o,
  output logic [$clog2(DEPTH)-1:0]   cur_addr_o,
  output logic                       done_o,
  output logic                       err_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LW    = $clog2(DEPTH + 1);
  localparam int unsigned CW    = $clog2(CLKS_PER_MS + 1);
  localparam int unsigned CNT_W = DELAY_W + CW;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t             state_q;
  logic [AW-1:0]      addr_q;
  logic [LW-1:0]      len_q;
  logic               loop_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [2:0]         mem_type  [DEPTH];
  logic [15:0]        mem_data  [DEPTH];
  logic [DELAY_W-1:0] mem_delay [DEPTH];

  logic               at_last;
  logic               wait_done;
  logic [AW-1:0]      issue_addr;
  logic               bypass;
  logic [2:0]         ent_type;
  logic [15:0]        ent_data;
  logic [DELAY_W-1:0] ent_delay;
  logic [CNT_W-1:0]   ent_cnt;
  logic               bad_type;
  logic               go_issue;

  // Script storage: writable only while idle, never reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !busy_o) begin
      mem_type[wr_addr_i]  <= wr_type_i;
      mem_data[wr_addr_i]  <= wr_data_i;
      mem_delay[wr_addr_i] <= wr_delay_i;
    end
  end

  // Select the next entry to issue and decide whether an issue happens this cycle.
  always_comb begin
    at_last    = (LW'(addr_q) + LW'(1)) == len_q;
    wait_done  = cnt_q <= CNT_W'(1);
    issue_addr = '0;
    if (state_q == WAIT && !at_last) begin
      issue_addr = addr_q + AW'(1);
    end
    // A write landing in the same idle cycle as start must be seen by entry 0,
    // so forward the write port around the storage array.
    bypass    = wr_en_i && !busy_o && (wr_addr_i == issue_addr);
    ent_type  = bypass ? wr_type_i  : mem_type[issue_addr];
    ent_data  = bypass ? wr_data_i  : mem_data[issue_addr];
    ent_delay = bypass ? wr_delay_i : mem_delay[issue_addr];
    ent_cnt   = CNT_W'(ent_delay) * CNT_W'(CLKS_PER_MS);
`ifdef TRAFFIC_CMD_PLAYER_TYPE_CHECK_EN
    bad_type  = ent_type[2:1] == 2'b11;
`else
    bad_type  = 1'b0;
`endif
    go_issue  = !stop_i &&
                ((state_q == IDLE && start_i && prog_len_i != '0) ||
                 (state_q == WAIT && wait_done && (!at_last || loop_q)));
  end

  // Playback FSM with registered command bus and status outputs.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q            <= IDLE;
      addr_q             <= '0;
      len_q              <= '0;
      loop_q             <= 1'b0;
      cnt_q              <= '0;
      cmd_if.cmd_type_o  <= '0;
      cmd_if.cmd_valid_o <= 1'b0;
      cmd_if.cmd_data_o  <= '0;
      busy_o             <= 1'b0;
      cur_addr_o         <= '0;
      done_o             <= 1'b0;
      err_o              <= 1'b0;
    end else begin
      cmd_if.cmd_valid_o <= 1'b0;
      done_o             <= 1'b0;
      if (stop_i) begin
        state_q <= IDLE;
        busy_o  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start_i) begin
              len_q  <= prog_len_i;
              loop_q <= loop_i;
              addr_q <= '0;
              if (prog_len_i == '0) begin
                done_o <= 1'b1;
              end
            end
          end
          ISSUE: state_q <= WAIT;
          WAIT: begin
            if (!wait_done) begin
              cnt_q <= cnt_q - CNT_W'(1);
            end else if (at_last && !loop_q) begin
              state_q <= IDLE;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
      // Issue overrides the case transitions above; go_issue already excludes stop.
      if (go_issue) begin
        state_q    <= ISSUE;
        busy_o     <= 1'b1;
        addr_q     <= issue_addr;
        cur_addr_o <= issue_addr;
        cnt_q      <= ent_cnt;
        if (bad_type) begin
          err_o <= 1'b1;
        end else begin
          cmd_if.cmd_valid_o <= 1'b1;
          cmd_if.cmd_type_o  <= ent_type;
          cmd_if.cmd_data_o  <= ent_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_traffic_cmd_player.sv
// Directed self-checking bench for traffic_cmd_player.
// Cycle k of a playback is the negedge after the k-th posedge following the
// cycle in which start_i was high.
module tb_traffic_cmd_player;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        wr_en_i;
  logic [2:0]  wr_addr_i;
  logic [2:0]  wr_type_i;
  logic [15:0] wr_data_i;
  logic [15:0] wr_delay_i;
  logic [3:0]  prog_len_i;
  logic        loop_i;
  logic        start_i;
  logic        stop_i;
  logic        busy_o;
  logic [2:0]  cur_addr_o;
  logic        done_o;
  logic        err_o;

  int n_checks = 0;
  int n_errors = 0;

  traffic_cmd_player_if cmd_if ();

  traffic_cmd_player #(
    .DEPTH       (8),
    .CLKS_PER_MS (2),
    .DELAY_W     (16)
  ) dut (
    .clk_i      (clk_i),
    .arstn_i    (arstn_i),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_type_i  (wr_type_i),
    .wr_data_i  (wr_data_i),
    .wr_delay_i (wr_delay_i),
    .prog_len_i (prog_len_i),
    .loop_i     (loop_i),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .cmd_if     (cmd_if),
    .busy_o     (busy_o),
    .cur_addr_o (cur_addr_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input int k, input logic v, input logic b, input logic d);
    chk($sformatf("%s valid k=%0d", tag, k), 32'(cmd_if.cmd_valid_o), 32'(v));
    chk($sformatf("%s busy k=%0d", tag, k), 32'(busy_o), 32'(b));
    chk($sformatf("%s done k=%0d", tag, k), 32'(done_o), 32'(d));
  endtask

  task automatic chk_cmd(input string tag, input int k, input logic [2:0] t, input logic [15:0] d, input logic [2:0] a);
    chk($sformatf("%s type k=%0d", tag, k), 32'(cmd_if.cmd_type_o), 32'(t));
    chk($sformatf("%s data k=%0d", tag, k), 32'(cmd_if.cmd_data_o), 32'(d));
    chk($sformatf("%s addr k=%0d", tag, k), 32'(cur_addr_o), 32'(a));
  endtask

  // Called at a negedge; the write is sampled at the following posedge.
  task automatic wr(input logic [2:0] a, input logic [2:0] t, input logic [15:0] d, input logic [15:0] dl);
    wr_en_i = 1'b1; wr_addr_i = a; wr_type_i = t; wr_data_i = d; wr_delay_i = dl;
    @(negedge clk_i);
    wr_en_i = 1'b0;
  endtask

  initial begin
    arstn_i = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_type_i = '0; wr_data_i = '0;
    wr_delay_i = '0; prog_len_i = '0; loop_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;

    // Reset state
    #12;
    chk("rst valid", 32'(cmd_if.cmd_valid_o), 32'd0);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst done", 32'(done_o), 32'd0);
    chk("rst err", 32'(err_o), 32'd0);
    chk("rst type", 32'(cmd_if.cmd_type_o), 32'd0);
    chk("rst data", 32'(cmd_if.cmd_data_o), 32'd0);
    chk("rst addr", 32'(cur_addr_o), 32'd0);
    @(negedge clk_i); arstn_i = 1'b1; @(negedge clk_i);

    wr(3'd0, 3'd0, 16'h0000, 16'd2);
    wr(3'd1, 3'd3, 16'h0005, 16'd0);
    wr(3'd2, 3'd4, 16'h000A, 16'd1);

    // One-shot playback: strobes at 1, 6, 8; done and busy fall at 11
    prog_len_i = 4'd3; loop_i = 1'b0; start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      chk_status("once", k, (k == 1 || k == 6 || k == 8), (k <= 10), (k == 11));
      if (k == 1) chk_cmd("once", k, 3'd0, 16'h0000, 3'd0);
      if (k == 6) chk_cmd("once", k, 3'd3, 16'h0005, 3'd1);
      if (k == 7) chk_cmd("once hold", k, 3'd3, 16'h0005, 3'd1);
      if (k == 8) chk_cmd("once", k, 3'd4, 16'h000A, 3'd2);
      @(negedge clk_i);
    end

    // Looped playback, stopped during cycle 13
    loop_i = 1'b1; start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0; loop_i = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      chk_status("loop", k, (k == 1 || k == 6 || k == 8 || k == 11), (k <= 13), 1'b0);
      if (k == 11) chk_cmd("loop wrap", k, 3'd0, 16'h0000, 3'd0);
      stop_i = (k == 13);
      @(negedge clk_i);
    end

    // Zero-length program
    prog_len_i = 4'd0; start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk_status("len0", k, 1'b0, 1'b0, (k == 1));
      @(negedge clk_i);
    end
    prog_len_i = 4'd3;

    // Stop in the same cycle as a scheduled issue suppresses it
    start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk_status("stopiss", k, (k == 1), (k <= 5), 1'b0);
      stop_i = (k == 5);
      @(negedge clk_i);
    end

    // Write while busy is ignored
    start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      chk_status("wrbusy", k, (k == 1 || k == 6 || k == 8), (k <= 10), (k == 11));
      if (k == 6) chk_cmd("wrbusy", k, 3'd3, 16'h0005, 3'd1);
      wr_en_i = (k == 2); wr_addr_i = 3'd1; wr_type_i = 3'd5; wr_data_i = 16'h0077; wr_delay_i = 16'd0;
      @(negedge clk_i);
    end

    // Rewrite entry 1 idle, then write entry 0 in the start cycle
    wr(3'd1, 3'd5, 16'h0077, 16'd0);
    wr_en_i = 1'b1; wr_addr_i = 3'd0; wr_type_i = 3'd2; wr_data_i = 16'h1234; wr_delay_i = 16'd2;
    start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0; wr_en_i = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      chk_status("rewr", k, (k == 1 || k == 6 || k == 8), (k <= 10), (k == 11));
      if (k == 1) chk_cmd("rewr", k, 3'd2, 16'h1234, 3'd0);
      if (k == 6) chk_cmd("rewr", k, 3'd5, 16'h0077, 3'd1);
      if (k == 8) chk_cmd("rewr", k, 3'd4, 16'h000A, 3'd2);
      @(negedge clk_i);
    end

    // Asynchronous reset during WAIT after entry 1
    start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    for (int k = 1; k < 7; k++) @(negedge clk_i);
    chk_cmd("prerst", 7, 3'd5, 16'h0077, 3'd1);
    chk("prerst busy", 32'(busy_o), 32'd1);
    #2 arstn_i = 1'b0;
    #1;
    chk("arst valid", 32'(cmd_if.cmd_valid_o), 32'd0);
    chk("arst busy", 32'(busy_o), 32'd0);
    chk("arst done", 32'(done_o), 32'd0);
    chk_cmd("arst", 0, 3'd0, 16'h0000, 3'd0);
    @(negedge clk_i); arstn_i = 1'b1;
    @(negedge clk_i);
    prog_len_i = 4'd3; loop_i = 1'b0; start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      chk_status("postrst", k, (k == 1 || k == 6 || k == 8), (k <= 10), (k == 11));
      if (k == 1) chk_cmd("postrst", k, 3'd2, 16'h1234, 3'd0);
      @(negedge clk_i);
    end

    // Entry 1 with type 7
    wr(3'd1, 3'd7, 16'h0042, 16'd0);
    start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    for (int k = 1; k <= 12; k++) begin
`ifdef TRAFFIC_CMD_PLAYER_TYPE_CHECK_EN
      chk_status("type7", k, (k == 1 || k == 8), (k <= 10), (k == 11));
      chk($sformatf("type7 err k=%0d", k), 32'(err_o), 32'(k >= 6));
      if (k == 6) chk_cmd("type7 held", k, 3'd2, 16'h1234, 3'd1);
`else
      chk_status("type7", k, (k == 1 || k == 6 || k == 8), (k <= 10), (k == 11));
      chk($sformatf("type7 err k=%0d", k), 32'(err_o), 32'd0);
      if (k == 6) chk_cmd("type7", k, 3'd7, 16'h0042, 3'd1);
`endif
      if (k == 8) chk_cmd("type7 next", k, 3'd4, 16'h000A, 3'd2);
      @(negedge clk_i);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/traffic_cmd_player.md
Name: traffic_cmd_player

Overview:
Programmable command source that sits directly upstream of the traffic-light controller and drives its cmd_type/cmd_valid/cmd_data interface. Software or a bench loads a short script of commands, each with a post-issue delay in ms. On start_i the block replays the script with the programmed spacing, once or looped. It replaces hand-driven command stimulus at board level and in system tests.

Parameters:
DEPTH, 8, number of script entries (power of 2, >=2)
CLKS_PER_MS, 2, clock cycles per millisecond of delay
DELAY_W, 16, width of per-entry delay field in ms

Ports:
clk_i  in  1  clock
arstn_i  in  1  asynchronous active-low reset
wr_en_i  in  1  script write strobe
wr_addr_i  in  $clog2(DEPTH)  script entry index
wr_type_i  in  3  command type to store
wr_data_i  in  16  command data to store
wr_delay_i  in  DELAY_W  ms to wait after this command is issued
prog_len_i  in  $clog2(DEPTH+1)  number of entries to play, 0..DEPTH; sampled on start
loop_i  in  1  replay from entry 0 after last entry; sampled on start
start_i  in  1  begin playback (level, acted on in IDLE only)
stop_i  in  1  abort playback
cmd_type_o  out  3  command type to controller
cmd_valid_o  out  1  one-cycle command strobe
cmd_data_o  out  16  command data to controller
busy_o  out  1  playback in progress
cur_addr_o  out  $clog2(DEPTH)  index of the last issued entry
done_o  out  1  one-cycle pulse at normal end of non-looped playback
err_o  out  1  sticky illegal-type flag (see Optional Feature)

Behaviour:
- Reset (arstn_i low, async): state IDLE; all outputs 0; counters 0. Script memory is not reset (contents undefined until written).
- All outputs registered. cmd_type_o/cmd_data_o hold the last issued value between strobes.
- Writes: accepted only when busy_o=0; ignored while busy. A write and start_i in the same IDLE cycle: the write lands, and playback uses the new entry.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: start_i=1 and stop_i=0 -> latch prog_len_i and loop_i, addr=0. If latched len=0, stay IDLE and pulse done_o next cycle. Otherwise go to ISSUE.
- ISSUE (1 cycle): cmd_valid_o=1 for the entry at addr; cur_addr_o=addr; load wait count = delay*CLKS_PER_MS (full-width multiply, no truncation); go to WAIT.
- Latency: start_i sampled at cycle N -> busy_o=1 and cmd_valid_o=1 with entry 0 at cycle N+1.
- WAIT: count down. When the count is 0 (immediately if delay=0), advance:
  - addr<len-1: addr+1 -> ISSUE.
  - addr=len-1 with loop: addr=0 -> ISSUE.
  - addr=len-1 without loop: IDLE; done_o pulses in the same cycle busy_o falls.
- Consecutive strobes are therefore spaced exactly 1+delay*CLKS_PER_MS cycles apart (delay=0 gives a strobe every other cycle).
- stop_i: highest priority in any state. Next cycle is IDLE, busy_o=0, no done_o, no further cmd_valid_o. A stop in the same cycle as a scheduled issue suppresses that issue.
- start_i while busy is ignored. prog_len_i/loop_i changes during playback have no effect.
- cur_addr_o wraps DEPTH-1 -> 0 only via loop. The address counter never exceeds len-1.
- An asynchronous reset mid-playback aborts immediately: strobe low, state IDLE.

Optional Feature:
TRAFFIC_CMD_PLAYER_TYPE_CHECK_EN
- Defined: an entry with cmd type 6 or 7 is not issued. Its ISSUE cycle has cmd_valid_o=0, cmd_type_o/cmd_data_o keep their previous values, and err_o sets and stays set until reset. The entry's delay is still honoured.
- Undefined: all types are issued as stored, and err_o is tied 0.

Test Plan:
- Load 3 entries {0,0x0000,2},{3,0x0005,0},{4,0x000A,1}, len=3, loop=0, start at cycle N -> strobes at N+1, N+6, N+8 with the stored type/data; done_o pulses at N+11, busy_o falls at N+11.
- Same script with loop=1 -> entry 0 re-issued at N+11, then N+16, ...; done_o never pulses; stop_i at N+13 -> busy_o=0 at N+14 and no strobe at N+16.
- len=0, start -> no cmd_valid_o; done_o single pulse one cycle later; busy_o stays 0.
- Write entry 1 while busy -> write ignored; after playback ends, rewrite entry 1 and replay -> the new value is issued.
- Assert arstn_i low mid-WAIT -> all outputs 0 asynchronously; after release, start replays from entry 0 with the retained script.
- With TRAFFIC_CMD_PLAYER_TYPE_CHECK_EN, entry 1 type=7 -> no strobe for entry 1, err_o=1 from then on, entry 2 issued on schedule; without the macro, type 7 is issued and err_o=0.
